// File: rtl/axil_to_apb.sv
// AXI4-Lite slave to APB3 master bridge.
// One APB transfer at a time. AW, W and AR are captured in independent
// holding registers. Reads and writes are granted round-robin. A per-access
// timeout answers DECERR when a peripheral never raises pready.
// Every output is driven straight from a flop.

module axil_to_apb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  // AXI-Lite write address
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  // AXI-Lite write data
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  // AXI-Lite write response
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  // AXI-Lite read address
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  // AXI-Lite read data
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  // APB master
  output logic [ADDR_WIDTH-1:0] m_apb_paddr,
  output logic                  m_apb_psel,
  output logic                  m_apb_penable,
  output logic                  m_apb_pwrite,
  output logic [DATA_WIDTH-1:0] m_apb_pwdata,
  input  logic [DATA_WIDTH-1:0] m_apb_prdata,
  input  logic                  m_apb_pready,
  input  logic                  m_apb_pslverr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP_W,
    ST_RESP_R
  } state_e;

  localparam logic [1:0]  RespOkay      = 2'b00;
  localparam logic [1:0]  RespSlvErr    = 2'b10;
  localparam logic [1:0]  RespDecErr    = 2'b11;
  localparam bit          TimeoutEnable = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TimeoutLimit  = 16'(TIMEOUT_CYCLES);

  state_e state_q, state_d;

  // Holding registers; the ready flop doubles as the inverted held flag
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;

  // Round-robin memory: 1 when the most recent grant was a write
  logic                  last_write_q, last_write_d;

  // APB side registers
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic                  pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic [15:0]           cnt_q,     cnt_d;

  // AXI response registers
  logic [1:0]            bresp_q,   bresp_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;

  logic       write_elig;
  logic       read_elig;
  logic       grant_w;
  logic       grant_r;
  logic       timeout_hit;
  logic       access_done;
  logic       b_hs;
  logic       r_hs;
  logic [1:0] access_resp;

  assign write_elig = !awready_q && !wready_q;
  assign read_elig  = !arready_q;

  // On a tie the type that did not win the previous grant goes first
  assign grant_w = write_elig && (!read_elig || !last_write_q);
  assign grant_r = read_elig && !grant_w;

  // pready has priority over a timeout landing in the same cycle
  assign timeout_hit = TimeoutEnable && (cnt_q == TimeoutLimit) && !m_apb_pready;
  assign access_done = m_apb_pready || timeout_hit;
  assign access_resp = m_apb_pready ? (m_apb_pslverr ? RespSlvErr : RespOkay) : RespDecErr;

  assign b_hs = bvalid_q && s_axil_bready;
  assign r_hs = rvalid_q && s_axil_rready;

  // State register; reset abandons any APB transfer in progress
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_w || grant_r) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (access_done) begin
          state_d = pwrite_q ? ST_RESP_W : ST_RESP_R;
        end
      end
      ST_RESP_W: begin
        if (b_hs) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP_R: begin
        if (r_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of every output and datapath register, decoded from the current state
  always_comb begin
    awready_d    = awready_q;
    wready_d     = wready_q;
    arready_d    = arready_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    araddr_d     = araddr_q;
    last_write_d = last_write_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    cnt_d        = cnt_q;
    bresp_d      = bresp_q;
    bvalid_d     = bvalid_q;
    rresp_d      = rresp_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;

    // Channel captures run in every state so a read can queue behind a write and vice versa
    if (s_axil_awvalid && awready_q) begin
      awready_d = 1'b0;
      awaddr_d  = s_axil_awaddr;
    end
    if (s_axil_wvalid && wready_q) begin
      wready_d = 1'b0;
      wdata_d  = s_axil_wdata;
    end
    if (s_axil_arvalid && arready_q) begin
      arready_d = 1'b0;
      araddr_d  = s_axil_araddr;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_w || grant_r) begin
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = grant_w;
          paddr_d      = grant_w ? awaddr_q : araddr_q;
          pwdata_d     = grant_w ? wdata_q : '0;
          last_write_d = grant_w;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        if (access_done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pwrite_q) begin
            bresp_d  = access_resp;
            bvalid_d = 1'b1;
          end else begin
            rresp_d  = access_resp;
            rvalid_d = 1'b1;
            rdata_d  = m_apb_pready ? m_apb_prdata : '0;
          end
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP_W: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      ST_RESP_R: begin
        if (r_hs) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers; readies come out of reset high, everything else low
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      awready_q    <= 1'b1;
      wready_q     <= 1'b1;
      arready_q    <= 1'b1;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      araddr_q     <= '0;
      last_write_q <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      cnt_q        <= '0;
      bresp_q      <= RespOkay;
      bvalid_q     <= 1'b0;
      rresp_q      <= RespOkay;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      arready_q    <= arready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      araddr_q     <= araddr_d;
      last_write_q <= last_write_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      cnt_q        <= cnt_d;
      bresp_q      <= bresp_d;
      bvalid_q     <= bvalid_d;
      rresp_q      <= rresp_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_arready = arready_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign m_apb_paddr    = paddr_q;
  assign m_apb_psel     = psel_q;
  assign m_apb_penable  = penable_q;
  assign m_apb_pwrite   = pwrite_q;
  assign m_apb_pwdata   = pwdata_q;

endmodule

// File: tb/tb_axil_to_apb.sv
// Directed testbench for axil_to_apb with a small APB slave model
// (word memory, programmable wait states, slave error and stuck modes).

module tb_axil_to_apb;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awAddr = '0;
  logic        awValid = 1'b0;
  logic        awReady;
  logic [31:0] wData = '0;
  logic        wValid = 1'b0;
  logic        wReady;
  logic [1:0]  bResp;
  logic        bValid;
  logic        bReady = 1'b0;
  logic [31:0] arAddr = '0;
  logic        arValid = 1'b0;
  logic        arReady;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rValid;
  logic        rReady = 1'b0;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  // Slave model controls
  int          waitStates = 0;
  int          waitCnt = 0;
  logic        slvErr = 1'b0;
  logic        stuck = 1'b0;
  logic [31:0] mem [0:63];

  // Completed-transfer log and gap monitor
  logic [31:0] apbLogAddr [0:63];
  logic        apbLogWrite [0:63];
  int          apbCount = 0;
  int          gapViolations = 0;
  logic        prevAccess = 1'b0;

  int assertCount = 0;
  int failCount = 0;

  axil_to_apb #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(aresetn),
    .s_axil_awaddr(awAddr),
    .s_axil_awvalid(awValid),
    .s_axil_awready(awReady),
    .s_axil_wdata(wData),
    .s_axil_wvalid(wValid),
    .s_axil_wready(wReady),
    .s_axil_bresp(bResp),
    .s_axil_bvalid(bValid),
    .s_axil_bready(bReady),
    .s_axil_araddr(arAddr),
    .s_axil_arvalid(arValid),
    .s_axil_arready(arReady),
    .s_axil_rdata(rData),
    .s_axil_rresp(rResp),
    .s_axil_rvalid(rValid),
    .s_axil_rready(rReady),
    .m_apb_paddr(paddr),
    .m_apb_psel(psel),
    .m_apb_penable(penable),
    .m_apb_pwrite(pwrite),
    .m_apb_pwdata(pwdata),
    .m_apb_prdata(prdata),
    .m_apb_pready(pready),
    .m_apb_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  assign pready  = psel && penable && !stuck && (waitCnt >= waitStates);
  assign prdata  = mem[paddr[7:2]];
  assign pslverr = slvErr;

  // Slave model: wait-state counter, memory writes, transfer log
  always @(posedge clk) begin
    if (!(psel && penable) || pready) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
    if (psel && penable && pready) begin
      if (pwrite) mem[paddr[7:2]] <= pwdata;
      if (apbCount < 64) begin
        apbLogAddr[apbCount]  <= paddr;
        apbLogWrite[apbCount] <= pwrite;
      end
      apbCount <= apbCount + 1;
    end
  end

  // A SETUP phase that directly follows an ACCESS phase means no idle gap
  always @(negedge clk) begin
    if (psel && !penable && prevAccess) gapViolations++;
    prevAccess = psel && penable;
  end

  // Issue AW and W together, wait for B, then accept it
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         output logic [1:0] resp, output int cycles,
                         output int pselCyc, output int penCyc, output logic pselAtResp);
    cycles = 0; pselCyc = 0; penCyc = 0;
    @(negedge clk);
    awAddr = addr; wData = data; awValid = 1'b1; wValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0;
    while (bValid !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (psel === 1'b1) pselCyc++;
      if (penable === 1'b1) penCyc++;
    end
    assertCount++;
    if (bValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL write_bvalid_bound: bvalid=%b required 1 within 100 cycles", bValid);
    end
    resp = bResp; pselAtResp = psel;
    bReady = 1'b1;
    @(negedge clk);
    bReady = 1'b0;
  endtask

  // Issue AR, wait for R, then accept it
  task automatic doRead(input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp, output int cycles);
    cycles = 0;
    @(negedge clk);
    arAddr = addr; arValid = 1'b1;
    @(negedge clk);
    arValid = 1'b0;
    while (rValid !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    assertCount++;
    if (rValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL read_rvalid_bound: rvalid=%b required 1 within 100 cycles", rValid);
    end
    data = rData; resp = rResp;
    rReady = 1'b1;
    @(negedge clk);
    rReady = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({awReady, wReady, arReady} !== 3'b111) begin
      failCount++; $display("[TB] FAIL reset_readies: got %b required 111", {awReady, wReady, arReady});
    end
    assertCount++;
    if ({psel, penable, pwrite, bValid, rValid} !== 5'b0) begin
      failCount++; $display("[TB] FAIL reset_controls: got %b required 00000", {psel, penable, pwrite, bValid, rValid});
    end
    assertCount++;
    if ({paddr, pwdata, rData} !== 96'h0) begin
      failCount++; $display("[TB] FAIL reset_data: paddr=%h pwdata=%h rdata=%h required 0", paddr, pwdata, rData);
    end
    assertCount++;
    if ({bResp, rResp} !== 4'b0) begin
      failCount++; $display("[TB] FAIL reset_resp: bresp=%b rresp=%b required 00", bResp, rResp);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_single_write();
    $display("[TB] test_single_write");
    @(negedge clk);
    awAddr = 32'h0000_0010; wData = 32'hDEAD_BEEF; awValid = 1'b1; wValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0;
    assertCount++;
    if ({awReady, wReady} !== 2'b00) begin
      failCount++; $display("[TB] FAIL sw_ready_low: got %b required 00", {awReady, wReady});
    end
    @(negedge clk);
    assertCount++;
    if ({psel, penable, pwrite} !== 3'b101) begin
      failCount++; $display("[TB] FAIL sw_setup: psel/penable/pwrite=%b required 101", {psel, penable, pwrite});
    end
    assertCount++;
    if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
      failCount++; $display("[TB] FAIL sw_addr_data: paddr=%h pwdata=%h required 10 deadbeef", paddr, pwdata);
    end
    @(negedge clk);
    assertCount++;
    if ({psel, penable} !== 2'b11) begin
      failCount++; $display("[TB] FAIL sw_access: psel/penable=%b required 11", {psel, penable});
    end
    @(negedge clk);
    assertCount++;
    if ({psel, bValid, bResp} !== 4'b0100) begin
      failCount++; $display("[TB] FAIL sw_resp: psel=%b bvalid=%b bresp=%b required 0 1 00", psel, bValid, bResp);
    end
    bReady = 1'b1;
    @(negedge clk);
    bReady = 1'b0;
    assertCount++;
    if ({bValid, awReady, wReady} !== 3'b011) begin
      failCount++; $display("[TB] FAIL sw_after_b: bvalid/awready/wready=%b required 011", {bValid, awReady, wReady});
    end
    assertCount++;
    if (mem[4] !== 32'hDEAD_BEEF) begin
      failCount++; $display("[TB] FAIL sw_slave_mem: got %h required deadbeef", mem[4]);
    end
  endtask

  task automatic test_write_read_wait();
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc, ps, pe;
    logic        pr;
    $display("[TB] test_write_read_wait");
    doWrite(32'h20, 32'h1234_5678, resp, cyc, ps, pe, pr);
    assertCount++;
    if (resp !== 2'b00 || cyc != 3) begin
      failCount++; $display("[TB] FAIL wr_write: bresp=%b cycles=%0d required 00 3", resp, cyc);
    end
    waitStates = 3;
    doRead(32'h20, data, resp, cyc);
    waitStates = 0;
    assertCount++;
    if (data !== 32'h1234_5678 || resp !== 2'b00) begin
      failCount++; $display("[TB] FAIL wr_read_data: rdata=%h rresp=%b required 12345678 00", data, resp);
    end
    assertCount++;
    if (cyc != 6) begin
      failCount++; $display("[TB] FAIL wr_read_latency: got %0d cycles required 6", cyc);
    end
    assertCount++;
    if (arReady !== 1'b1) begin
      failCount++; $display("[TB] FAIL wr_arready_back: got %b required 1", arReady);
    end
  endtask

  task automatic test_tie_arbitration();
    int          base;
    int          n;
    logic [1:0]  resp;
    int          cyc, ps, pe;
    logic        pr;
    $display("[TB] test_tie_arbitration");
    base = apbCount;
    bReady = 1'b1; rReady = 1'b1;
    @(negedge clk);
    wData = 32'hAAAA_0001; wValid = 1'b1;
    @(negedge clk);
    wValid = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({wReady, psel} !== 2'b00) begin
      failCount++; $display("[TB] FAIL tie_w_alone_waits: wready/psel=%b required 00", {wReady, psel});
    end
    awAddr = 32'h50; awValid = 1'b1; arAddr = 32'h54; arValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; arValid = 1'b0;
    n = 0;
    while (!(apbCount >= base + 2 && awReady && wReady && arReady) && n < 60) begin
      @(negedge clk); n++;
    end
    assertCount++;
    if ({apbLogWrite[base], apbLogAddr[base]} !== {1'b1, 32'h50}) begin
      failCount++; $display("[TB] FAIL tie1_first: write=%b addr=%h required 1 50", apbLogWrite[base], apbLogAddr[base]);
    end
    assertCount++;
    if ({apbLogWrite[base+1], apbLogAddr[base+1]} !== {1'b0, 32'h54}) begin
      failCount++; $display("[TB] FAIL tie1_second: write=%b addr=%h required 0 54", apbLogWrite[base+1], apbLogAddr[base+1]);
    end
    bReady = 1'b0; rReady = 1'b0;
    doWrite(32'h58, 32'hAAAA_0002, resp, cyc, ps, pe, pr);
    bReady = 1'b1; rReady = 1'b1;
    @(negedge clk);
    awAddr = 32'h5C; wData = 32'hAAAA_0003; arAddr = 32'h60;
    awValid = 1'b1; wValid = 1'b1; arValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
    n = 0;
    while (!(apbCount >= base + 5 && awReady && wReady && arReady) && n < 60) begin
      @(negedge clk); n++;
    end
    bReady = 1'b0; rReady = 1'b0;
    assertCount++;
    if ({apbLogWrite[base+3], apbLogAddr[base+3]} !== {1'b0, 32'h60}) begin
      failCount++; $display("[TB] FAIL tie2_first: write=%b addr=%h required 0 60", apbLogWrite[base+3], apbLogAddr[base+3]);
    end
    assertCount++;
    if ({apbLogWrite[base+4], apbLogAddr[base+4]} !== {1'b1, 32'h5C}) begin
      failCount++; $display("[TB] FAIL tie2_second: write=%b addr=%h required 1 5c", apbLogWrite[base+4], apbLogAddr[base+4]);
    end
    assertCount++;
    if (gapViolations != 0) begin
      failCount++; $display("[TB] FAIL back_to_back_gap: got %0d violations required 0", gapViolations);
    end
  endtask

  task automatic test_slave_error();
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
    $display("[TB] test_slave_error");
    slvErr = 1'b1;
    doRead(32'h40, data, resp, cyc);
    slvErr = 1'b0;
    assertCount++;
    if (resp !== 2'b10) begin
      failCount++; $display("[TB] FAIL slverr_resp: rresp=%b required 10", resp);
    end
    assertCount++;
    if (data !== 32'hCAFE_F00D) begin
      failCount++; $display("[TB] FAIL slverr_data: rdata=%h required cafef00d", data);
    end
  endtask

  task automatic test_timeout();
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc, ps, pe;
    logic        pr;
    $display("[TB] test_timeout");
    stuck = 1'b1;
    doWrite(32'h30, 32'h0BAD_0BAD, resp, cyc, ps, pe, pr);
    assertCount++;
    if (resp !== 2'b11 || pr !== 1'b0) begin
      failCount++; $display("[TB] FAIL to_write_resp: bresp=%b psel=%b required 11 0", resp, pr);
    end
    assertCount++;
    if (pe != 5 || cyc != 7) begin
      failCount++; $display("[TB] FAIL to_write_timing: penable cycles=%0d latency=%0d required 5 7", pe, cyc);
    end
    doRead(32'h34, data, resp, cyc);
    assertCount++;
    if (resp !== 2'b11 || data !== 32'h0) begin
      failCount++; $display("[TB] FAIL to_read: rresp=%b rdata=%h required 11 0", resp, data);
    end
    stuck = 1'b0;
    doRead(32'h20, data, resp, cyc);
    assertCount++;
    if (resp !== 2'b00 || data !== 32'h1234_5678 || cyc != 3) begin
      failCount++; $display("[TB] FAIL to_recover: rresp=%b rdata=%h cycles=%0d required 00 12345678 3", resp, data, cyc);
    end
    assertCount++;
    if (mem[12] !== 32'h0) begin
      failCount++; $display("[TB] FAIL to_no_write: mem=%h required 0", mem[12]);
    end
  endtask

  task automatic test_backpressure_reset();
    int          n;
    logic [1:0]  resp;
    int          cyc, ps, pe;
    logic        pr;
    $display("[TB] test_backpressure_reset");
    @(negedge clk);
    awAddr = 32'h44; wData = 32'h55AA_55AA; awValid = 1'b1; wValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0;
    n = 0;
    while (bValid !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      assertCount++;
      if ({bValid, bResp, awReady, wReady} !== 5'b10000) begin
        failCount++; $display("[TB] FAIL bp_hold_%0d: bvalid/bresp/awready/wready=%b required 10000", i, {bValid, bResp, awReady, wReady});
      end
    end
    bReady = 1'b1;
    @(negedge clk);
    bReady = 1'b0;
    stuck = 1'b1;
    awAddr = 32'h48; wData = 32'h7777_7777; awValid = 1'b1; wValid = 1'b1;
    @(negedge clk);
    awValid = 1'b0; wValid = 1'b0;
    n = 0;
    while (penable !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    arAddr = 32'h4C; arValid = 1'b1;
    @(negedge clk);
    arValid = 1'b0;
    assertCount++;
    if ({psel, penable, arReady} !== 3'b110) begin
      failCount++; $display("[TB] FAIL rst_pre_state: psel/penable/arready=%b required 110", {psel, penable, arReady});
    end
    aresetn = 1'b0;
    #1;
    assertCount++;
    if ({psel, penable, bValid, rValid} !== 4'b0000) begin
      failCount++; $display("[TB] FAIL rst_async_drop: psel/penable/bvalid/rvalid=%b required 0000", {psel, penable, bValid, rValid});
    end
    assertCount++;
    if ({awReady, wReady, arReady} !== 3'b111) begin
      failCount++; $display("[TB] FAIL rst_async_ready: got %b required 111", {awReady, wReady, arReady});
    end
    stuck = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    doWrite(32'h4C, 32'h0F0F_0F0F, resp, cyc, ps, pe, pr);
    assertCount++;
    if (resp !== 2'b00 || cyc != 3 || ps != 2) begin
      failCount++; $display("[TB] FAIL rst_after_write: bresp=%b cycles=%0d psel cycles=%0d required 00 3 2", resp, cyc, ps);
    end
    repeat (3) @(negedge clk);
    assertCount++;
    if ({psel, rValid, arReady} !== 3'b001) begin
      failCount++; $display("[TB] FAIL rst_ar_cleared: psel/rvalid/arready=%b required 001", {psel, rValid, arReady});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[16] = 32'hCAFE_F00D;
    test_reset();
    test_single_write();
    test_write_read_wait();
    test_tie_arbitration();
    test_slave_error();
    test_timeout();
    test_backpressure_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
